// File: rtl/rv32i_pkg.sv
// Shared RV32I definitions: opcode/funct constants, control enums and the
// funct3 -> ALU operation mapping used by both OP and OP-IMM decode.
package rv32i_pkg;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    localparam logic [2:0] F3_ADD_SUB = 3'b000;
    localparam logic [2:0] F3_SLL     = 3'b001;
    localparam logic [2:0] F3_SLT     = 3'b010;
    localparam logic [2:0] F3_SLTU    = 3'b011;
    localparam logic [2:0] F3_XOR     = 3'b100;
    localparam logic [2:0] F3_SRL_SRA = 3'b101;
    localparam logic [2:0] F3_OR      = 3'b110;
    localparam logic [2:0] F3_AND     = 3'b111;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [2:0] F3_WORD = 3'b010;
    localparam logic [6:0] F7_BASE = 7'b0000000;
    localparam logic [6:0] F7_ALT  = 7'b0100000;

    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_e;

    typedef enum logic [2:0] {
        WB_NONE, WB_ALU, WB_MEM, WB_PC4, WB_IMM, WB_PC_IMM
    } wb_sel_e;

    typedef enum logic [1:0] {
        PC_SEQ, PC_REL, PC_JALR
    } pc_sel_e;

    // alt selects SUB/SRA; callers only raise it where funct7 permits.
    function automatic alu_op_e alu_op_from(input logic [2:0] f3, input logic alt);
        case (f3)
            F3_ADD_SUB: return alt ? ALU_SUB : ALU_ADD;
            F3_SLL:     return ALU_SLL;
            F3_SLT:     return ALU_SLT;
            F3_SLTU:    return ALU_SLTU;
            F3_XOR:     return ALU_XOR;
            F3_SRL_SRA: return alt ? ALU_SRA : ALU_SRL;
            F3_OR:      return ALU_OR;
            F3_AND:     return ALU_AND;
            default:    return ALU_ADD;
        endcase
    endfunction

endpackage

// File: rtl/rv32i_alu.sv
// RV32I integer ALU: result for the selected operation plus the equality and
// signed/unsigned less-than flags that drive branch resolution.
module rv32i_alu
    import rv32i_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  alu_op_e     op,
    output logic [31:0] result,
    output logic        eq,
    output logic        lt,
    output logic        ltu
);
    logic signed [31:0] a_s;
    logic signed [31:0] b_s;
    logic        [4:0]  shamt;

    assign a_s   = a;
    assign b_s   = b;
    assign shamt = b[4:0];

    assign eq  = (a == b);
    assign lt  = (a_s < b_s);
    assign ltu = (a < b);

    always_comb begin
        result = '0;
        case (op)
            ALU_ADD:  result = a + b;
            ALU_SUB:  result = a - b;
            ALU_SLL:  result = a << shamt;
            ALU_SLT:  result = {31'd0, lt};
            ALU_SLTU: result = {31'd0, ltu};
            ALU_XOR:  result = a ^ b;
            ALU_SRL:  result = a >> shamt;
            ALU_SRA:  result = a_s >>> shamt;
            ALU_OR:   result = a | b;
            ALU_AND:  result = a & b;
            default:  result = '0;
        endcase
    end

endmodule

// File: rtl/rv32i_core.sv
// Single-cycle RV32I core: decode and execute are combinational from
// Prog_BUS_READ; register writeback and PC update share the rising edge.
module rv32i_core
    import rv32i_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        CLK,
    input  logic        Reset,
    input  logic [31:0] Prog_BUS_READ,
    input  logic [31:0] Data_BUS_READ,
    output logic [31:0] ADDR_Prog,
    output logic        CS_P,
    output logic [31:0] ADDR,
    output logic [31:0] Data_BUS_WRITE,
    output logic        CS,
    output logic        WE
);
    logic [31:0] pc, pc_next, pc_raw, pc_plus4, pc_target;
    logic [31:0] regs [32];
    logic [31:0] instr, rs1_val, rs2_val, alu_b, alu_result, wb_data;
    logic [31:0] imm, imm_i, imm_s, imm_b, imm_u, imm_j;
    logic [6:0]  opcode, funct7;
    logic [2:0]  funct3;
    logic [4:0]  rd, rs1, rs2;
    alu_op_e     alu_op;
    wb_sel_e     wb_sel;
    pc_sel_e     pc_sel;
    logic        use_rs2, is_branch, mem_rd, mem_wr;
    logic        br_eq, br_lt, br_ltu, br_taken;
    logic        op_legal, op_imm_legal;

    assign instr  = Prog_BUS_READ;
    assign opcode = instr[6:0];
    assign rd     = instr[11:7];
    assign funct3 = instr[14:12];
    assign rs1    = instr[19:15];
    assign rs2    = instr[24:20];
    assign funct7 = instr[31:25];

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'd0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    // Register reads see the pre-edge contents, so same-cycle writes are not forwarded.
    assign rs1_val = (rs1 == 5'd0) ? '0 : regs[rs1];
    assign rs2_val = (rs2 == 5'd0) ? '0 : regs[rs2];

    // funct7 encodings outside the base ISA (e.g. M extension) fall through as NOPs.
    assign op_legal     = (funct7 == F7_BASE) ||
                          (funct7 == F7_ALT && (funct3 == F3_ADD_SUB || funct3 == F3_SRL_SRA));
    assign op_imm_legal = (funct3 == F3_SLL)     ? (funct7 == F7_BASE) :
                          (funct3 == F3_SRL_SRA) ? (funct7 == F7_BASE || funct7 == F7_ALT) :
                          1'b1;

    always_comb begin
        imm       = '0;
        alu_op    = ALU_ADD;
        use_rs2   = 1'b0;
        is_branch = 1'b0;
        wb_sel    = WB_NONE;
        pc_sel    = PC_SEQ;
        mem_rd    = 1'b0;
        mem_wr    = 1'b0;
        case (opcode)
            OPC_LUI: begin
                imm    = imm_u;
                wb_sel = WB_IMM;
            end
            OPC_AUIPC: begin
                imm    = imm_u;
                wb_sel = WB_PC_IMM;
            end
            OPC_JAL: begin
                imm    = imm_j;
                wb_sel = WB_PC4;
                pc_sel = PC_REL;
            end
            OPC_JALR: if (funct3 == 3'b000) begin
                imm    = imm_i;
                wb_sel = WB_PC4;
                pc_sel = PC_JALR;
            end
            OPC_BRANCH: begin
                imm       = imm_b;
                use_rs2   = 1'b1;
                is_branch = 1'b1;
            end
            OPC_LOAD: if (funct3 == F3_WORD) begin
                imm    = imm_i;
                mem_rd = 1'b1;
                wb_sel = WB_MEM;
            end
            OPC_STORE: if (funct3 == F3_WORD) begin
                imm    = imm_s;
                mem_wr = 1'b1;
            end
            OPC_OP_IMM: if (op_imm_legal) begin
                imm    = imm_i;
                alu_op = alu_op_from(funct3, funct3 == F3_SRL_SRA && funct7 == F7_ALT);
                wb_sel = WB_ALU;
            end
            OPC_OP: if (op_legal) begin
                use_rs2 = 1'b1;
                alu_op  = alu_op_from(funct3, funct7 == F7_ALT);
                wb_sel  = WB_ALU;
            end
            default: ;
        endcase
    end

    assign alu_b = use_rs2 ? rs2_val : imm;

    rv32i_alu u_alu (
        .a      (rs1_val),
        .b      (alu_b),
        .op     (alu_op),
        .result (alu_result),
        .eq     (br_eq),
        .lt     (br_lt),
        .ltu    (br_ltu)
    );

    always_comb begin
        case (funct3)
            F3_BEQ:  br_taken = br_eq;
            F3_BNE:  br_taken = !br_eq;
            F3_BLT:  br_taken = br_lt;
            F3_BGE:  br_taken = !br_lt;
            F3_BLTU: br_taken = br_ltu;
            F3_BGEU: br_taken = !br_ltu;
            default: br_taken = 1'b0;
        endcase
    end

    assign pc_plus4  = pc + 32'd4;
    assign pc_target = pc + imm;

    always_comb begin
        pc_raw = pc_plus4;
        if (pc_sel == PC_JALR)
            pc_raw = alu_result & ~32'd1;
        else if (pc_sel == PC_REL || (is_branch && br_taken))
            pc_raw = pc_target;
        pc_next = pc_raw & ~32'd3;
    end

    always_comb begin
        case (wb_sel)
            WB_ALU:    wb_data = alu_result;
            WB_MEM:    wb_data = Data_BUS_READ;
            WB_PC4:    wb_data = pc_plus4;
            WB_IMM:    wb_data = imm;
            WB_PC_IMM: wb_data = pc_target;
            default:   wb_data = '0;
        endcase
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset)
            pc <= RESET_PC;
        else
            pc <= pc_next;
    end

    always_ff @(posedge CLK or negedge Reset) begin
        if (!Reset) begin
            for (int i = 0; i < 32; i++)
                regs[i] <= '0;
        end else if (wb_sel != WB_NONE && rd != 5'd0) begin
            regs[rd] <= wb_data;
        end
    end

    // Bus outputs are held inactive for as long as Reset is low.
    assign ADDR_Prog      = pc;
    assign CS_P           = Reset;
    assign CS             = Reset && (mem_rd || mem_wr);
    assign WE             = Reset && mem_wr;
    assign ADDR           = Reset ? alu_result : '0;
    assign Data_BUS_WRITE = Reset ? rs2_val : '0;

endmodule

// File: tb/tb_rv32i_core.sv
// Bench for rv32i_core: a directed program table with hand-derived results,
// reset corner cases, then random instructions against an ISA-level model.
module tb_rv32i_core;

    logic        CLK = 1'b0;
    logic        Reset;
    logic [31:0] Prog_BUS_READ, Data_BUS_READ;
    logic [31:0] ADDR_Prog, ADDR, Data_BUS_WRITE;
    logic        CS_P, CS, WE;

    int n_pass  = 0;
    int n_total = 0;

    logic [31:0] m_regs [32];
    logic [31:0] m_pc;

    localparam logic [6:0] O_LUI = 7'h37, O_AUIPC = 7'h17, O_JALR = 7'h67;
    localparam logic [6:0] O_LOAD = 7'h03, O_IMM = 7'h13;

    always #5 CLK = ~CLK;

    rv32i_core #(.RESET_PC(32'h0000_0000)) dut (
        .CLK            (CLK),
        .Reset          (Reset),
        .Prog_BUS_READ  (Prog_BUS_READ),
        .Data_BUS_READ  (Data_BUS_READ),
        .ADDR_Prog      (ADDR_Prog),
        .CS_P           (CS_P),
        .ADDR           (ADDR),
        .Data_BUS_WRITE (Data_BUS_WRITE),
        .CS             (CS),
        .WE             (WE)
    );

    initial begin
        #500000;
        $display("FAIL watchdog: run did not complete, got timeout want finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", name, act, exp);
    endtask

    function automatic logic [31:0] enc_i(input logic [6:0] op, input logic [2:0] f3,
                                          input int rd, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im, 5'(rs1), f3, 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_r(input logic [6:0] f7, input logic [2:0] f3,
                                          input int rd, input int rs1, input int rs2);
        return {f7, 5'(rs2), 5'(rs1), f3, 5'(rd), 7'h33};
    endfunction

    function automatic logic [31:0] enc_s(input int rs2, input int rs1, input int imm);
        logic [11:0] im;
        im = 12'(imm);
        return {im[11:5], 5'(rs2), 5'(rs1), 3'b010, im[4:0], 7'h23};
    endfunction

    function automatic logic [31:0] enc_b(input logic [2:0] f3, input int rs1, input int rs2, input int imm);
        logic [12:0] im;
        im = 13'(imm);
        return {im[12], im[10:5], 5'(rs2), 5'(rs1), f3, im[4:1], im[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_u(input logic [6:0] op, input int rd, input int imm20);
        return {20'(imm20), 5'(rd), op};
    endfunction

    function automatic logic [31:0] enc_j(input int rd, input int imm);
        logic [20:0] im;
        im = 21'(imm);
        return {im[20], im[10:1], im[11], im[19:12], 5'(rd), 7'h6F};
    endfunction

    // ---------------- ISA-level reference model ----------------
    function automatic logic [31:0] alu_ref(input logic [2:0] f3, input logic alt,
                                            input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0:    return alt ? x - y : x + y;
            3'd1:    return x << y[4:0];
            3'd2:    return ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'd3:    return (x < y) ? 32'd1 : 32'd0;
            3'd4:    return x ^ y;
            3'd5:    return alt ? $signed(x) >>> y[4:0] : x >> y[4:0];
            3'd6:    return x | y;
            default: return x & y;
        endcase
    endfunction

    function automatic logic br_ref(input logic [2:0] f3, input logic [31:0] x, input logic [31:0] y);
        case (f3)
            3'd0:    return x == y;
            3'd1:    return x != y;
            3'd4:    return $signed(x) < $signed(y);
            3'd5:    return $signed(x) >= $signed(y);
            3'd6:    return x < y;
            3'd7:    return x >= y;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_exec(input logic [31:0] ins, input logic [31:0] dr,
                              output logic cs, output logic we,
                              output logic [31:0] addr, output logic [31:0] wd,
                              output logic [31:0] npc, output logic wr,
                              output logic [4:0] rd, output logic [31:0] wv);
        logic [31:0] a, b, ii, is, ib, iu, ij;
        logic [6:0]  op, f7;
        logic [2:0]  f3;
        op = ins[6:0];  f3 = ins[14:12];  f7 = ins[31:25];  rd = ins[11:7];
        a  = m_regs[ins[19:15]];
        b  = m_regs[ins[24:20]];
        ii = {{20{ins[31]}}, ins[31:20]};
        is = {{20{ins[31]}}, ins[31:25], ins[11:7]};
        ib = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
        iu = {ins[31:12], 12'd0};
        ij = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
        cs = 0; we = 0; addr = 0; wd = b; npc = m_pc + 4; wr = 0; wv = 0;
        case (op)
            7'h37: begin wr = 1; wv = iu; end
            7'h17: begin wr = 1; wv = m_pc + iu; end
            7'h6F: begin wr = 1; wv = m_pc + 4; npc = m_pc + ij; end
            7'h67: if (f3 == 0) begin wr = 1; wv = m_pc + 4; npc = (a + ii) & ~32'd1; end
            7'h63: if (br_ref(f3, a, b)) npc = m_pc + ib;
            7'h03: if (f3 == 2) begin cs = 1; addr = a + ii; wr = 1; wv = dr; end
            7'h23: if (f3 == 2) begin cs = 1; we = 1; addr = a + is; end
            7'h13: if (!(f3 == 1 && f7 != 0) && !(f3 == 5 && f7 != 0 && f7 != 7'h20)) begin
                wr = 1; wv = alu_ref(f3, f3 == 5 && ins[30], a, ii);
            end
            7'h33: if (f7 == 0 || (f7 == 7'h20 && (f3 == 0 || f3 == 5))) begin
                wr = 1; wv = alu_ref(f3, ins[30], a, b);
            end
            default: ;
        endcase
        npc = npc & ~32'd3;
    endtask

    task automatic mstep(input logic [31:0] ins, input logic [31:0] dr, input string tag);
        logic        e_cs, e_we, e_wr;
        logic [31:0] e_addr, e_wd, e_npc, e_wv;
        logic [4:0]  e_rd;
        Prog_BUS_READ = ins;
        Data_BUS_READ = dr;
        model_exec(ins, dr, e_cs, e_we, e_addr, e_wd, e_npc, e_wr, e_rd, e_wv);
        #1;
        chk({tag, ".pc"}, ADDR_Prog, m_pc);
        chk({tag, ".cs_p"}, {31'd0, CS_P}, 32'd1);
        chk({tag, ".cs"}, {31'd0, CS}, {31'd0, e_cs});
        chk({tag, ".we"}, {31'd0, WE}, {31'd0, e_we});
        if (e_cs) chk({tag, ".addr"}, ADDR, e_addr);
        if (e_we) chk({tag, ".wdata"}, Data_BUS_WRITE, e_wd);
        if (e_wr && e_rd != 0) m_regs[e_rd] = e_wv;
        m_pc = e_npc;
        @(posedge CLK);
        #2;
    endtask

    function automatic logic [31:0] rand_instr();
        int k, rd, rs1, rs2, imm;
        logic [2:0] f3;
        logic [2:0] bf [6];
        bf[0] = 3'd0; bf[1] = 3'd1; bf[2] = 3'd4; bf[3] = 3'd5; bf[4] = 3'd6; bf[5] = 3'd7;
        k   = $urandom_range(0, 11);
        rd  = $urandom_range(0, 7);
        rs1 = $urandom_range(0, 7);
        rs2 = $urandom_range(0, 7);
        f3  = 3'($urandom_range(0, 7));
        imm = int'($urandom_range(0, 4095)) - 2048;
        case (k)
            0, 1, 2: begin
                if (f3 == 3'd1) imm = $urandom_range(0, 31);
                else if (f3 == 3'd5) imm = $urandom_range(0, 31) + ($urandom_range(0, 1) != 0 ? 'h400 : 0);
                return enc_i(O_IMM, f3, rd, rs1, imm);
            end
            3: return enc_r(($urandom_range(0, 1) != 0 && (f3 == 0 || f3 == 5)) ? 7'h20 : 7'h00,
                            f3, rd, rs1, rs2);
            4: return enc_u(O_LUI, rd, $urandom);
            5: return enc_u(O_AUIPC, rd, $urandom);
            6: return enc_i(O_LOAD, 3'd2, rd, rs1, imm);
            7: return enc_s(rs2, rs1, imm);
            8: return enc_b(bf[$urandom_range(0, 5)], rs1, rs2, int'($urandom_range(0, 8191)) - 4096);
            9: return enc_j(rd, $urandom);
            10: return enc_i(O_JALR, 3'd0, rd, rs1, imm);
            default: begin
                case ($urandom_range(0, 7))
                    0: return 32'h0000_000F;
                    1: return 32'h0000_0073;
                    2: return enc_i(O_LOAD, 3'd0, rd, rs1, imm);
                    3: return enc_s(rs2, rs1, imm) & ~32'h0000_7000;
                    4: return 32'hFFFF_FFFF;
                    5: return enc_r(7'h01, f3, rd, rs1, rs2);
                    6: return enc_i(O_IMM, 3'd1, rd, rs1, 'h400 + $urandom_range(0, 31));
                    default: return enc_b(3'd2, rs1, rs2, 8);
                endcase
            end
        endcase
    endfunction

    // ---------------- directed program table ----------------
    typedef struct {
        logic [31:0] pc;
        logic [31:0] ins;
        logic [31:0] dr;
        logic        cs;
        logic        we;
        logic        chk_addr;
        logic [31:0] addr;
        logic        chk_wd;
        logic [31:0] wd;
    } vec_t;

    vec_t vt[$];

    task automatic add_vec(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] dr,
                           input logic cs, input logic we, input logic chk_addr,
                           input logic [31:0] addr, input logic chk_wd, input logic [31:0] wd);
        vec_t v;
        v.pc = pc; v.ins = ins; v.dr = dr; v.cs = cs; v.we = we;
        v.chk_addr = chk_addr; v.addr = addr; v.chk_wd = chk_wd; v.wd = wd;
        vt.push_back(v);
    endtask

    task automatic v_nop(input logic [31:0] pc, input logic [31:0] ins);
        add_vec(pc, ins, 32'h0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
    endtask

    task automatic v_sw(input logic [31:0] pc, input logic [31:0] ins, input logic [31:0] addr,
                        input logic [31:0] wd);
        add_vec(pc, ins, 32'h0, 1'b1, 1'b1, 1'b1, addr, 1'b1, wd);
    endtask

    initial begin
        v_nop(32'h00, enc_i(O_IMM, 3'd0, 1, 0, 5));
        v_nop(32'h04, enc_i(O_IMM, 3'd0, 2, 0, -3));
        v_nop(32'h08, enc_r(7'h00, 3'd0, 3, 1, 2));
        v_nop(32'h0C, enc_r(7'h00, 3'd2, 4, 2, 1));
        v_nop(32'h10, enc_i(O_IMM, 3'd5, 5, 2, 'h401));
        v_nop(32'h14, enc_i(O_IMM, 3'd0, 0, 0, 7));
        v_sw (32'h18, enc_s(3, 0, 0), 32'h0, 32'h0000_0002);
        v_sw (32'h1C, enc_s(4, 0, 0), 32'h0, 32'h0000_0001);
        v_sw (32'h20, enc_s(5, 0, 0), 32'h0, 32'hFFFF_FFFE);
        v_sw (32'h24, enc_s(0, 0, 0), 32'h0, 32'h0000_0000);
        v_nop(32'h28, enc_u(O_LUI, 6, 'h12345));
        v_sw (32'h2C, enc_s(6, 0, 8), 32'h8, 32'h1234_5000);
        add_vec(32'h30, enc_i(O_LOAD, 3'd2, 7, 0, 4), 32'hDEAD_BEEF, 1'b1, 1'b0, 1'b1, 32'h4, 1'b0, 32'h0);
        v_sw (32'h34, enc_s(7, 0, 0), 32'h0, 32'hDEAD_BEEF);
        v_nop(32'h38, enc_b(3'd0, 1, 1, -8));
        v_nop(32'h30, enc_b(3'd1, 1, 1, -8));
        v_nop(32'h34, enc_j(1, 'h20));
        v_nop(32'h54, enc_i(O_JALR, 3'd0, 0, 1, 3));
        v_sw (32'h38, enc_s(1, 0, 0), 32'h0, 32'h0000_0038);
        v_nop(32'h3C, 32'h0000_000F);
        v_nop(32'h40, 32'hFFFF_FFFF);
        v_sw (32'h44, enc_s(1, 0, 0), 32'h0, 32'h0000_0038);
        v_nop(32'h48, enc_b(3'd4, 2, 1, 12));
        v_nop(32'h54, enc_b(3'd6, 2, 1, 8));
        v_nop(32'h58, enc_b(3'd5, 2, 1, 8));
        v_nop(32'h5C, enc_b(3'd7, 2, 1, 8));
        v_nop(32'h64, enc_u(O_AUIPC, 8, 1));
        v_sw (32'h68, enc_s(8, 0, 0), 32'h0, 32'h0000_1064);

        // Reset held across two edges with a store on the bus: outputs stay forced.
        Reset = 1'b0;
        Prog_BUS_READ = enc_s(0, 0, 8);
        Data_BUS_READ = 32'h0;
        repeat (2) @(posedge CLK);
        #2;
        chk("rst.addr_prog", ADDR_Prog, 32'h0);
        chk("rst.cs_p", {31'd0, CS_P}, 32'd0);
        chk("rst.cs", {31'd0, CS}, 32'd0);
        chk("rst.we", {31'd0, WE}, 32'd0);
        chk("rst.addr", ADDR, 32'h0);
        chk("rst.wdata", Data_BUS_WRITE, 32'h0);
        Reset = 1'b1;

        for (int i = 0; i < vt.size(); i++) begin
            Prog_BUS_READ = vt[i].ins;
            Data_BUS_READ = vt[i].dr;
            #1;
            chk($sformatf("v%0d.pc", i), ADDR_Prog, vt[i].pc);
            chk($sformatf("v%0d.cs_p", i), {31'd0, CS_P}, 32'd1);
            chk($sformatf("v%0d.cs", i), {31'd0, CS}, {31'd0, vt[i].cs});
            chk($sformatf("v%0d.we", i), {31'd0, WE}, {31'd0, vt[i].we});
            if (vt[i].chk_addr) chk($sformatf("v%0d.addr", i), ADDR, vt[i].addr);
            if (vt[i].chk_wd) chk($sformatf("v%0d.wdata", i), Data_BUS_WRITE, vt[i].wd);
            @(posedge CLK);
            #2;
        end
        chk("dir.final_pc", ADDR_Prog, 32'h6C);

        // Asynchronous reset mid-cycle; the pending ADDI x9 must not land.
        Prog_BUS_READ = enc_i(O_IMM, 3'd0, 9, 0, 99);
        Reset = 1'b0;
        #1;
        chk("midrst.pc", ADDR_Prog, 32'h0);
        chk("midrst.cs_p", {31'd0, CS_P}, 32'd0);
        @(posedge CLK);
        #2;
        Reset = 1'b1;
        for (int i = 0; i < 32; i++) m_regs[i] = 32'h0;
        m_pc = 32'h0;
        mstep(enc_s(9, 0, 0), 32'h0, "post_rst_x9");
        mstep(enc_s(8, 0, 4), 32'h0, "post_rst_x8");

        for (int i = 0; i < 500; i++)
            mstep(rand_instr(), $urandom, $sformatf("rnd%0d", i));

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/rv32i_core.md
# rv32i_core

Single-cycle RV32I integer core: fetches one 32-bit instruction per clock from a program bus, executes it, and accesses data memory over a separate data bus (Harvard). It is the processing element of the SoC, sitting between program ROM and data RAM. Both memories have combinational (same-cycle) read.

## Interface
Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.

Ports:
- CLK  in  1  single system clock; all state updates on rising edge.
- Reset  in  1  asynchronous, active-low reset.
- Prog_BUS_READ  in  32  instruction word at ADDR_Prog.
- Data_BUS_READ  in  32  data word at ADDR, valid same cycle.
- ADDR_Prog  out  32  program byte address, equal to PC.
- CS_P  out  1  program memory select.
- ADDR  out  32  data byte address (rs1 + imm).
- Data_BUS_WRITE  out  32  store data (rs2).
- CS  out  1  data memory select, high for LW/SW.
- WE  out  1  data write enable, high for SW only.

## Operation
- Instruction support: LUI, AUIPC, JAL, JALR, BEQ/BNE/BLT/BGE/BLTU/BGEU, LW, SW, all OP-IMM and OP ALU ops (ADD, SUB, SLL, SLT, SLTU, XOR, SRL, SRA, OR, AND).
- Other load/store widths, FENCE, SYSTEM, unknown opcodes: executed as NOP (PC+4, no write, CS=WE=0).
- 32 x 32-bit registers; x0 reads 0, writes to x0 discarded.
- Immediates sign-extended per RV32I I/S/B/U/J formats.
- Shift amount = low 5 bits of operand; SLT signed, SLTU unsigned compare.
- Arithmetic modulo 2^32, no overflow flags.
- Writeback mux: ALU result, Data_BUS_READ (LW), PC+4 (JAL/JALR), imm (LUI), PC+imm (AUIPC).
- Next PC: PC+4; branch taken/JAL: PC+imm; JALR: (rs1+imm) with bit 0 cleared. Next PC bits [1:0] forced to 0.
- ADDR carries full byte address; memory ignores [1:0]. No misalignment trap.

## Timing
- Reset asserted (Reset=0): PC=RESET_PC, all registers 0, CS_P=0, CS=0, WE=0, ADDR=0, Data_BUS_WRITE=0 (outputs forced while asserted).
- After deassertion: CS_P=1 continuously; ADDR_Prog=PC.
- One instruction per cycle (CPI=1). Decode, ALU, and data-bus outputs are combinational from Prog_BUS_READ and register contents.
- Register writeback and PC update on the same rising edge ending the cycle.
- SW: memory samples ADDR/Data_BUS_WRITE/WE on that edge.
- LW: Data_BUS_READ must be valid before that edge.
- Reset mid-instruction: the instruction is abandoned; no partial writeback.
- Register read of a register being written in the same cycle returns the old value. The new value is visible next cycle.

## Structure
- Shared package rv32i_pkg: opcode constants (7'b0110111 LUI, etc.), funct3/funct7 constants, ALU-op enum, writeback-select and PC-select enums.
- One natural sub-module: rv32i_alu (operands a, b, ALU op -> result, plus compare flags for branches).
- Register file and decode stay inline in the top.

## Test plan
- Reset: hold Reset=0 for 2 cycles -> ADDR_Prog=0, CS_P=0, CS=0, WE=0. Release -> CS_P=1, ADDR_Prog steps 0,4,8.
- ALU: ADDI x1,x0,5; ADDI x2,x0,-3; ADD x3,x1,x2; SLT x4,x2,x1; SRA x5,x2,1 -> x3=2, x4=1, x5=0xFFFFFFFE. ADDI x0,x0,7 leaves x0=0.
- Store: LUI x6,0x12345; SW x6,8(x0) -> that cycle ADDR=8, Data_BUS_WRITE=0x12345000, CS=1, WE=1.
- Load: LW x7,4(x0) with Data_BUS_READ=0xDEADBEEF -> ADDR=4, CS=1, WE=0, next cycle x7=0xDEADBEEF.
- Branches and jumps: at PC=0x10, BEQ x1,x1,-8 -> next PC=0x08. BNE x1,x1 -> PC=0x14. JAL x1,+0x20 at PC=0x20 -> PC=0x40, x1=0x24. JALR x0,0x3(x1) -> PC=0x26 with bit 0 cleared, then bits [1:0] forced to 0, giving PC=0x24.
- Illegal/unsupported: 0x0000000F (FENCE) and 0xFFFFFFFF -> PC+4, no register change, CS=WE=0.
